u8dbg_target: RTL
=================

// Module: u8dbg_target
// PURPOSE
// Target-side responder for the nX-U8 two-wire debug link (dbg_clk, dbg_sdata); the u8dbg host is the initiator.
// Oversamples the link in the local clock domain and decodes the 8-bit command {reg[6:0], dir}.
// Then either serialises 16 bits of register data to the host (dir=1) or captures 16 bits from it (dir=0).
// Sits between the debug pins and the target's debug register file.
// PARAMETERS
// SYNC_STAGES  2     flops in each input synchroniser (>=2)
// TIMEOUT      1024  clk cycles without a dbg_clk edge before an open transaction is abandoned
// TMO_W        11    width of the timeout counter; must hold TIMEOUT
// PORTS
// clk            in   1   local clock; must be >=8x the dbg_clk frequency
// rst            in   1   asynchronous, active-high reset
// dbg_clk        in   1   debug clock from host; idles high
// dbg_sdata_in   in   1   sdata pad input
// dbg_sdata_out  out  1   sdata pad output value
// dbg_sdata_oe   out  1   sdata pad output enable (1 = target drives)
// reg_addr       out  7   register address of the current transaction
// rd_stb         out  1   1-cycle read request for reg_addr
// rd_data        in   16  register value; sampled exactly 1 clk after rd_stb
// wr_stb         out  1   1-cycle write strobe; reg_addr/wr_data valid in the same cycle
// wr_data        out  16  captured write data
// busy           out  1   high whenever state != IDLE
// timeout_err    out  1   1-cycle pulse when a transaction is abandoned by timeout
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; shift registers and counters 0. Reset mid-transaction releases sdata at once (oe=0, async).
// - dbg_clk and dbg_sdata_in each pass through SYNC_STAGES flops; rise/fall strobes come from synced vs previous value.
//   Data is sampled from the synced sdata on the cycle a rise is detected.
// - Bit order is MSB first everywhere. The host drives on dbg_clk falling edges; the target samples on rising edges.
// - States (as seen by the implementation):
//   IDLE:  fall detected -> CMD; bit_cnt=0.
//   CMD:   each rise shifts one sampled bit into cmd_sr; bit_cnt++. After the 8th rise:
//          reg_addr<=cmd_sr[7:1];
//          if dir=1: pulse rd_stb and go to RLOAD;
//          else go to WRITE.
//          bit_cnt resets on either exit.
//   RLOAD: 1 cycle; latch rd_data into tx_sr -> READ.
//   READ:  on each fall, oe<=1, dbg_sdata_out<=tx_sr[15], tx_sr<<=1.
//          On each rise, bit_cnt++. On the 16th rise, oe<=0 in that cycle -> IDLE.
//   WRITE: each rise shifts a sampled bit into wr_data; bit_cnt++.
//          On the 16th rise, pulse wr_stb the following cycle with that value -> IDLE.
// - The target never drives sdata outside READ. In READ, oe first rises on the first data-phase falling edge.
// - rd_stb and wr_stb are mutually exclusive; exactly one strobe per complete transaction, none for an aborted one.
// - Timeout: any non-IDLE state with no dbg_clk edge for TIMEOUT cycles -> IDLE, oe=0, timeout_err pulse.
//   No strobe is issued; a partial write is discarded. The counter clears on every detected edge.
// - rd_data changing after RLOAD does not affect the bits being shifted out.
// - A fall arriving in the same cycle as the return to IDLE is ignored; a new transaction starts on the next fall.
// - bit_cnt is 5 bits and never wraps: the terminal counts are 8 (CMD) and 16 (READ/WRITE).
// STRUCTURE
// - Shared include u8dbg_defs.vh: state encodings (IDLE, CMD, RLOAD, READ, WRITE),
//   CMD_BITS=8, DATA_BITS=16, DIR_READ=1'b1. The u8dbg host uses the same include.
// - One sub-module u8dbg_edge_sync (synchroniser + rise/fall detect); instantiate it for dbg_clk.
//   dbg_sdata_in uses the synchroniser path only.
// TESTING
// - Write: host BFM sends cmd 0x2A then 0xBEEF -> exactly one wr_stb, reg_addr=0x15, wr_data=0xBEEF; oe stays 0 throughout.
// - Read: cmd 0xFF, rd_data=0x1234 -> rd_stb once, reg_addr=0x7F; host samples 0x1234; oe=0 after the 16th rise.
// - Read with rd_data changed to 0xFFFF two cycles after rd_stb, cmd 0x03 -> host still receives the originally latched value.
// - Timeout: 3 command bits then dbg_clk held high 1100 cycles -> timeout_err pulse, busy=0.
//   A following full write to reg 0x01 decodes correctly.
// - Reset mid-read (rst after the 5th data bit) -> oe=0 immediately, busy=0, no strobe.
//   A following read of 0x0A returns correct data.
// - Back-to-back write then read with no idle gap beyond the host's END cycle -> both complete with correct strobes and data.

Source files
------------

// File: rtl/u8dbg_target_pkg.sv
// Shared definitions for the nX-U8 debug link target: state encoding and
// frame geometry used by the target datapath and its bus interface.
package u8dbg_target_pkg;

   localparam int   CMD_BITS  = 8;
   localparam int   DATA_BITS = 16;
   localparam int   ADDR_BITS = CMD_BITS - 1;
   localparam logic DIR_READ  = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      RLOAD = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

endpackage

// File: rtl/u8dbg_target_if.sv
// Pin and register-file side signals of the debug target. The slave modport
// is the target's view; the master modport is the host/register-file view.
interface u8dbg_target_if;
   import u8dbg_target_pkg::*;

   logic                 dbg_clk;
   logic                 dbg_sdata_in;
   logic                 dbg_sdata_out;
   logic                 dbg_sdata_oe;
   logic [ADDR_BITS-1:0] reg_addr;
   logic                 rd_stb;
   logic [DATA_BITS-1:0] rd_data;
   logic                 wr_stb;
   logic [DATA_BITS-1:0] wr_data;
   logic                 busy;
   logic                 timeout_err;

   modport slave (
      input  dbg_clk, dbg_sdata_in, rd_data,
      output dbg_sdata_out, dbg_sdata_oe, reg_addr, rd_stb, wr_stb, wr_data,
             busy, timeout_err
   );

   modport master (
      output dbg_clk, dbg_sdata_in, rd_data,
      input  dbg_sdata_out, dbg_sdata_oe, reg_addr, rd_stb, wr_stb, wr_data,
             busy, timeout_err
   );

endinterface

// File: rtl/u8dbg_edge_sync.sv
// Synchronises an asynchronous input into clk and flags its rising and
// falling transitions as single-cycle strobes.
module u8dbg_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // Synchroniser chain plus one-cycle-delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev   <= synced;
      end
   end

   assign rise = synced & ~prev;
   assign fall = ~synced & prev;

endmodule

// File: rtl/u8dbg_target.sv
// nX-U8 debug link target: decodes {reg[6:0], dir} from the host, then either
// shifts 16 bits of register data out (dir=1) or captures 16 bits (dir=0).
//
// state | meaning
// IDLE  | link quiet, waiting for the host's first falling edge
// CMD   | shifting in the 8 command bits on dbg_clk rises
// RLOAD | one cycle while the register file answers rd_stb
// READ  | driving data on falls, counting host samples on rises
// WRITE | shifting in 16 write data bits on rises
module u8dbg_target
   import u8dbg_target_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024,
   parameter int TMO_W       = 11
) (
   input logic           clk,
   input logic           rst,
   u8dbg_target_if.slave bus
);

   state_t                 state;
   state_t                 state_nxt;
   logic                   clk_rise;
   logic                   clk_fall;
   logic                   dbg_edge;
   logic [SYNC_STAGES-1:0] sd_sync;
   logic                   sdata;
   logic [4:0]             bit_cnt;
   logic [CMD_BITS-2:0]    cmd_sr;
   logic [CMD_BITS-1:0]    cmd_new;
   logic [DATA_BITS-1:0]   tx_sr;
   logic [DATA_BITS-2:0]   wr_sr;
   logic [TMO_W-1:0]       tmo_cnt;
   logic                   cmd_done;
   logic                   data_done;
   logic                   tmo_hit;
   logic [ADDR_BITS-1:0]   reg_addr_q;
   logic                   rd_stb_q;
   logic                   wr_stb_q;
   logic [DATA_BITS-1:0]   wr_data_q;
   logic                   oe_q;
   logic                   sdata_out_q;
   logic                   tmo_err_q;

   u8dbg_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.dbg_clk),
      .rise (clk_rise),
      .fall (clk_fall)
   );

   // Plain synchroniser for sdata; it is only ever sampled on a dbg_clk rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sd_sync <= '0;
      else     sd_sync <= {sd_sync[SYNC_STAGES-2:0], bus.dbg_sdata_in};
   end

   assign sdata    = sd_sync[SYNC_STAGES-1];
   assign dbg_edge = clk_rise | clk_fall;
   assign cmd_new  = {cmd_sr, sdata};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode, terminal counts and timeout detection.
   always_comb begin
      state_nxt = state;
      cmd_done  = (state == CMD) && clk_rise && (bit_cnt == 5'(CMD_BITS - 1));
      data_done = ((state == READ) || (state == WRITE)) && clk_rise &&
                  (bit_cnt == 5'(DATA_BITS - 1));
      tmo_hit   = (state != IDLE) && !dbg_edge && (tmo_cnt == TMO_W'(TIMEOUT - 1));
      case (state)
         IDLE:    if (clk_fall) state_nxt = CMD;
         CMD:     if (cmd_done) state_nxt = (cmd_new[0] == DIR_READ) ? RLOAD : WRITE;
         RLOAD:   state_nxt = READ;
         READ:    if (data_done) state_nxt = IDLE;
         WRITE:   if (data_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (tmo_hit) state_nxt = IDLE;
   end

   // Inactivity counter: runs only inside a transaction, cleared by any edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              tmo_cnt <= '0;
      else if ((state == IDLE) || dbg_edge) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + TMO_W'(1);
   end

   // Shift registers, bit counter, strobes and pad drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt     <= '0;
         cmd_sr      <= '0;
         tx_sr       <= '0;
         wr_sr       <= '0;
         reg_addr_q  <= '0;
         rd_stb_q    <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_data_q   <= '0;
         oe_q        <= 1'b0;
         sdata_out_q <= 1'b0;
         tmo_err_q   <= 1'b0;
      end else begin
         rd_stb_q  <= 1'b0;
         wr_stb_q  <= 1'b0;
         tmo_err_q <= 1'b0;
         if (tmo_hit) begin
            tmo_err_q <= 1'b1;
            oe_q      <= 1'b0;
            bit_cnt   <= '0;
         end else begin
            case (state)
               IDLE: bit_cnt <= '0;
               CMD: begin
                  if (clk_rise) begin
                     cmd_sr <= cmd_new[CMD_BITS-2:0];
                     if (cmd_done) begin
                        reg_addr_q <= cmd_new[CMD_BITS-1:1];
                        rd_stb_q   <= (cmd_new[0] == DIR_READ);
                        bit_cnt    <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               RLOAD: tx_sr <= bus.rd_data;
               READ: begin
                  if (clk_fall) begin
                     oe_q        <= 1'b1;
                     sdata_out_q <= tx_sr[DATA_BITS-1];
                     tx_sr       <= {tx_sr[DATA_BITS-2:0], 1'b0};
                  end
                  if (clk_rise) begin
                     if (data_done) begin
                        oe_q    <= 1'b0;
                        bit_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               WRITE: begin
                  if (clk_rise) begin
                     wr_sr <= {wr_sr[DATA_BITS-3:0], sdata};
                     if (data_done) begin
                        wr_data_q <= {wr_sr, sdata};
                        wr_stb_q  <= 1'b1;
                        bit_cnt   <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               default: bit_cnt <= '0;
            endcase
         end
      end
   end

   assign bus.dbg_sdata_out = sdata_out_q;
   assign bus.dbg_sdata_oe  = oe_q;
   assign bus.reg_addr      = reg_addr_q;
   assign bus.rd_stb        = rd_stb_q;
   assign bus.wr_stb        = wr_stb_q;
   assign bus.wr_data       = wr_data_q;
   assign bus.busy          = (state != IDLE);
   assign bus.timeout_err   = tmo_err_q;

endmodule
